sram_bus_arbiter_n: RTL and testbench

- Parametrised N-channel SRAM-style bus arbiter. Funnels N cache/LSU requesters onto one downstream read port and one downstream write port that feed the AXI bridge.
- Generalises the fixed 4-port interconnect:
  - channel count, address, data, type and strobe widths are parameters;
  - fixed-priority or round-robin arbitration is selectable;
  - read and write paths are independent, each running its own grant-lock state machine.

---
 rtl/sram_bus_arbiter_n.sv | 184 ++++++++++++++++++
 tb/tb_sram_bus_arbiter_n.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter_n.sv
// N-channel SRAM-style bus arbiter.
// Independent read/write grant-lock FSMs onto one downstream port each.
module sram_bus_arbiter_n #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 256,
  parameter int TYPE_W   = 6,
  parameter int STRB_W   = 16,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        r_req,
  input  logic [NUM_CH*ADDR_W-1:0] r_addr,
  input  logic [NUM_CH*TYPE_W-1:0] r_type,
  output logic [NUM_CH-1:0]        r_rdy,
  output logic [DATA_W-1:0]        re_data,
  output logic [NUM_CH-1:0]        re_valid,
  input  logic [NUM_CH-1:0]        w_req,
  input  logic [NUM_CH*ADDR_W-1:0] w_addr,
  input  logic [NUM_CH*DATA_W-1:0] w_data,
  input  logic [NUM_CH*TYPE_W-1:0] w_type,
  input  logic [NUM_CH*STRB_W-1:0] w_strb,
  output logic [NUM_CH-1:0]        w_rdy,
  output logic                     m_r_req,
  output logic [ADDR_W-1:0]        m_r_addr,
  output logic [TYPE_W-1:0]        m_r_type,
  input  logic                     m_r_rdy,
  input  logic [DATA_W-1:0]        m_re_data,
  input  logic                     m_re_valid,
  output logic                     m_w_req,
  output logic [ADDR_W-1:0]        m_w_addr,
  output logic [DATA_W-1:0]        m_w_data,
  output logic [TYPE_W-1:0]        m_w_type,
  output logic [STRB_W-1:0]        m_w_strb,
  input  logic                     m_w_rdy,
  output logic                     rd_busy,
  output logic                     wr_busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT
  } rstate_t;

  typedef enum logic {
    W_IDLE,
    W_REQ
  } wstate_t;

  rstate_t         r_rstate;
  wstate_t         r_wstate;
  logic [CW-1:0]   r_rgnt;
  logic [CW-1:0]   r_wgnt;
  logic [CW-1:0]   r_rptr;
  logic [CW-1:0]   r_wptr;

  logic [NUM_CH-1:0] w_rreq_m;
  logic [NUM_CH-1:0] w_wreq_m;
  logic [CW-1:0]     w_rstart;
  logic [CW-1:0]     w_wstart;
  logic [CW-1:0]     w_rg;
  logic [CW-1:0]     w_wg;

  // First requesting channel at or after ptr, wrapping modulo NUM_CH.
  function automatic logic [CW-1:0] f_pick(
    input logic [NUM_CH-1:0] req,
    input logic [CW-1:0]     ptr
  );
    logic [CW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (req[idx]) pick = CW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [CW-1:0] f_next(input logic [CW-1:0] g);
    return (int'(g) == NUM_CH - 1) ? '0 : g + CW'(1);
  endfunction

  // The channel being acknowledged this cycle still holds its request.
  assign w_rreq_m = r_req & ~r_rdy;
  assign w_wreq_m = w_req & ~w_rdy;

  assign w_rstart = (ARB_MODE == 1) ? r_rptr : '0;
  assign w_wstart = (ARB_MODE == 1) ? r_wptr : '0;

  assign w_rg = f_pick(w_rreq_m, w_rstart);
  assign w_wg = f_pick(w_wreq_m, w_wstart);

  assign rd_busy = (r_rstate != R_IDLE);
  assign wr_busy = (r_wstate != W_IDLE);

  // Read path: grant, forward request downstream, return data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rgnt   <= '0;
      r_rptr   <= '0;
      r_rdy    <= '0;
      re_valid <= '0;
      re_data  <= '0;
      m_r_req  <= 1'b0;
      m_r_addr <= '0;
      m_r_type <= '0;
    end else begin
      r_rdy    <= '0;
      re_valid <= '0;
      unique case (r_rstate)
        R_IDLE: begin
          if (|w_rreq_m) begin
            r_rgnt        <= w_rg;
            m_r_addr      <= r_addr[w_rg*ADDR_W +: ADDR_W];
            m_r_type      <= r_type[w_rg*TYPE_W +: TYPE_W];
            r_rdy[w_rg]   <= 1'b1;
            m_r_req       <= 1'b1;
            r_rstate      <= R_REQ;
            if (ARB_MODE == 1) r_rptr <= f_next(w_rg);
          end
        end
        R_REQ: begin
          if (m_r_rdy) begin
            m_r_req  <= 1'b0;
            r_rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (m_re_valid) begin
            re_data          <= m_re_data;
            re_valid[r_rgnt] <= 1'b1;
            r_rstate         <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write path: grant, latch payload, hold until downstream accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_wgnt   <= '0;
      r_wptr   <= '0;
      w_rdy    <= '0;
      m_w_req  <= 1'b0;
      m_w_addr <= '0;
      m_w_data <= '0;
      m_w_type <= '0;
      m_w_strb <= '0;
    end else begin
      w_rdy <= '0;
      unique case (r_wstate)
        W_IDLE: begin
          if (|w_wreq_m) begin
            r_wgnt   <= w_wg;
            m_w_addr <= w_addr[w_wg*ADDR_W +: ADDR_W];
            m_w_data <= w_data[w_wg*DATA_W +: DATA_W];
            m_w_type <= w_type[w_wg*TYPE_W +: TYPE_W];
            m_w_strb <= w_strb[w_wg*STRB_W +: STRB_W];
            m_w_req  <= 1'b1;
            r_wstate <= W_REQ;
            if (ARB_MODE == 1) r_wptr <= f_next(w_wg);
          end
        end
        W_REQ: begin
          if (m_w_rdy) begin
            w_rdy[r_wgnt] <= 1'b1;
            m_w_req       <= 1'b0;
            r_wstate      <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter_n.sv
// Directed bench for sram_bus_arbiter_n.
// Fixed-priority instance driven by tasks; round-robin instance self-run.
module tb_sram_bus_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 6;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    r_req;
  logic [N*AW-1:0] r_addr;
  logic [N*TW-1:0] r_type;
  logic [N-1:0]    r_rdy;
  logic [DW-1:0]   re_data;
  logic [N-1:0]    re_valid;
  logic [N-1:0]    w_req;
  logic [N*AW-1:0] w_addr;
  logic [N*DW-1:0] w_data;
  logic [N*TW-1:0] w_type;
  logic [N*SW-1:0] w_strb;
  logic [N-1:0]    w_rdy;
  logic            m_r_req;
  logic [AW-1:0]   m_r_addr;
  logic [TW-1:0]   m_r_type;
  logic            m_r_rdy;
  logic [DW-1:0]   m_re_data;
  logic            m_re_valid;
  logic            m_w_req;
  logic [AW-1:0]   m_w_addr;
  logic [DW-1:0]   m_w_data;
  logic [TW-1:0]   m_w_type;
  logic [SW-1:0]   m_w_strb;
  logic            m_w_rdy;
  logic            rd_busy;
  logic            wr_busy;

  sram_bus_arbiter_n #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .TYPE_W(TW), .STRB_W(SW), .ARB_MODE(0)
  ) u_fp (
    .clk(clk), .rst_n(rst_n),
    .r_req(r_req), .r_addr(r_addr), .r_type(r_type),
    .r_rdy(r_rdy), .re_data(re_data), .re_valid(re_valid),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
    .w_type(w_type), .w_strb(w_strb), .w_rdy(w_rdy),
    .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type),
    .m_r_rdy(m_r_rdy), .m_re_data(m_re_data), .m_re_valid(m_re_valid),
    .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
    .m_w_type(m_w_type), .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy),
    .rd_busy(rd_busy), .wr_busy(wr_busy)
  );

  // Round-robin instance with an always-ready downstream responder.
  logic [N-1:0]    rr_r_req;
  logic [N-1:0]    rr_r_rdy;
  logic [DW-1:0]   rr_re_data;
  logic [N-1:0]    rr_re_valid;
  logic [N-1:0]    rr_w_rdy;
  logic            rr_m_r_req;
  logic [AW-1:0]   rr_m_r_addr;
  logic [TW-1:0]   rr_m_r_type;
  logic            rr_m_r_rdy;
  logic            rr_m_re_valid;
  logic            rr_m_w_req;
  logic [AW-1:0]   rr_m_w_addr;
  logic [DW-1:0]   rr_m_w_data;
  logic [TW-1:0]   rr_m_w_type;
  logic [SW-1:0]   rr_m_w_strb;
  logic            rr_rd_busy;
  logic            rr_wr_busy;
  logic [N*AW-1:0] rr_addr_c = {32'h3000, 32'h2000, 32'h1000, 32'h0};

  assign rr_m_r_rdy    = rr_m_r_req;
  assign rr_m_re_valid = rr_rd_busy & ~rr_m_r_req;

  sram_bus_arbiter_n #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .TYPE_W(TW), .STRB_W(SW), .ARB_MODE(1)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .r_req(rr_r_req), .r_addr(rr_addr_c), .r_type('0),
    .r_rdy(rr_r_rdy), .re_data(rr_re_data), .re_valid(rr_re_valid),
    .w_req('0), .w_addr('0), .w_data('0),
    .w_type('0), .w_strb('0), .w_rdy(rr_w_rdy),
    .m_r_req(rr_m_r_req), .m_r_addr(rr_m_r_addr),
    .m_r_type(rr_m_r_type), .m_r_rdy(rr_m_r_rdy),
    .m_re_data(256'h77), .m_re_valid(rr_m_re_valid),
    .m_w_req(rr_m_w_req), .m_w_addr(rr_m_w_addr),
    .m_w_data(rr_m_w_data), .m_w_type(rr_m_w_type),
    .m_w_strb(rr_m_w_strb), .m_w_rdy(1'b0),
    .rd_busy(rr_rd_busy), .wr_busy(rr_wr_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_rv   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Total re_valid pulses seen on the fixed-priority instance.
  always @(negedge clk) begin
    if (rst_n) n_rv += $countones(re_valid);
  end

  typedef struct {
    int           ch;
    logic [31:0]  addr;
    logic [5:0]   typ;
    logic [255:0] data;
    logic [3:0]   exp_rdy;
    logic [3:0]   exp_vld;
  } rd_vec_t;

  typedef struct {
    int           ch;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [5:0]   typ;
    logic [15:0]  strb;
    logic [3:0]   exp_rdy;
  } wr_vec_t;

  rd_vec_t rtv[3];
  wr_vec_t wtv[2];

  task automatic do_read(input rd_vec_t v);
    @(negedge clk);
    r_req[v.ch] = 1'b1;
    r_addr[v.ch*AW +: AW] = v.addr;
    r_type[v.ch*TW +: TW] = v.typ;
    @(negedge clk);
    chk("rd_rdy", r_rdy, v.exp_rdy);
    chk("rd_m_req", m_r_req, 1'b1);
    chk("rd_m_addr", m_r_addr, v.addr);
    chk("rd_m_type", m_r_type, v.typ);
    r_req[v.ch] = 1'b0;
    m_r_rdy = 1'b1;
    @(negedge clk);
    chk("rd_rdy_pulse", r_rdy, 4'b0);
    chk("rd_m_req_drop", m_r_req, 1'b0);
    chk("rd_busy_wait", rd_busy, 1'b1);
    m_r_rdy = 1'b0;
    m_re_valid = 1'b1;
    m_re_data = v.data;
    @(negedge clk);
    chk("rd_valid", re_valid, v.exp_vld);
    chk("rd_data", re_data, v.data);
    chk("rd_busy_idle", rd_busy, 1'b0);
    m_re_valid = 1'b0;
    @(negedge clk);
    chk("rd_valid_pulse", re_valid, 4'b0);
  endtask

  task automatic do_write(input wr_vec_t v);
    @(negedge clk);
    w_req[v.ch] = 1'b1;
    w_addr[v.ch*AW +: AW] = v.addr;
    w_data[v.ch*DW +: DW] = v.data;
    w_type[v.ch*TW +: TW] = v.typ;
    w_strb[v.ch*SW +: SW] = v.strb;
    @(negedge clk);
    chk("wr_m_req", m_w_req, 1'b1);
    chk("wr_m_addr", m_w_addr, v.addr);
    chk("wr_m_type", m_w_type, v.typ);
    chk("wr_m_strb", m_w_strb, v.strb);
    chk("wr_early_rdy", w_rdy, 4'b0);
    w_data[v.ch*DW +: DW] = ~v.data;
    w_addr[v.ch*AW +: AW] = ~v.addr;
    @(negedge clk);
    chk("wr_lock_data", m_w_data, v.data);
    chk("wr_lock_addr", m_w_addr, v.addr);
    m_w_rdy = 1'b1;
    @(negedge clk);
    chk("wr_rdy", w_rdy, v.exp_rdy);
    chk("wr_m_req_drop", m_w_req, 1'b0);
    m_w_rdy = 1'b0;
    @(negedge clk);
    chk("wr_no_regrant", m_w_req, 1'b0);
    chk("wr_rdy_pulse", w_rdy, 4'b0);
    w_req[v.ch] = 1'b0;
    @(negedge clk);
  endtask

  int rr_got[$];
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    rtv[0] = '{2, 32'h8000_0040, 6'h03, 256'hA5, 4'b0100, 4'b0100};
    rtv[1] = '{0, 32'h0000_1234, 6'h1F, ~256'h0, 4'b0001, 4'b0001};
    rtv[2] = '{3, 32'hFFFF_FFFC, 6'h3F, {8{32'hDEAD_BEEF}},
               4'b1000, 4'b1000};
    wtv[0] = '{1, 32'h8000_1000, 256'h1234_5678, 6'h02,
               16'h00FF, 4'b0010};
    wtv[1] = '{3, 32'h0000_0800, {4{64'hCAFE_F00D_0BAD_BEEF}}, 6'h21,
               16'hFFFF, 4'b1000};

    r_req = '0; r_addr = '0; r_type = '0;
    w_req = '0; w_addr = '0; w_data = '0; w_type = '0; w_strb = '0;
    m_r_rdy = 1'b0; m_re_data = '0; m_re_valid = 1'b0;
    m_w_rdy = 1'b0; rr_r_req = '0;

    repeat (2) @(negedge clk);
    chk("rst_r_rdy", r_rdy, 4'b0);
    chk("rst_re_valid", re_valid, 4'b0);
    chk("rst_m_r_req", m_r_req, 1'b0);
    chk("rst_m_w_req", m_w_req, 1'b0);
    chk("rst_busy", {rd_busy, wr_busy}, 2'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) do_read(rtv[i]);
    for (int i = 0; i < 2; i++) do_write(wtv[i]);

    // Fixed priority: ch1 beats ch3, then ch3 taken back-to-back.
    @(negedge clk);
    r_req = 4'b1010;
    r_addr[1*AW +: AW] = 32'h0000_0111;
    r_addr[3*AW +: AW] = 32'h0000_0333;
    @(negedge clk);
    chk("fp_first_rdy", r_rdy, 4'b0010);
    chk("fp_first_addr", m_r_addr, 32'h0000_0111);
    r_req[1] = 1'b0;
    m_r_rdy = 1'b1;
    @(negedge clk);
    m_r_rdy = 1'b0;
    m_re_valid = 1'b1;
    m_re_data = 256'h11;
    @(negedge clk);
    chk("fp_first_vld", re_valid, 4'b0010);
    m_re_valid = 1'b0;
    @(negedge clk);
    chk("fp_second_rdy", r_rdy, 4'b1000);
    chk("fp_second_addr", m_r_addr, 32'h0000_0333);
    r_req[3] = 1'b0;
    m_r_rdy = 1'b1;
    @(negedge clk);
    m_r_rdy = 1'b0;
    m_re_valid = 1'b1;
    m_re_data = 256'h33;
    @(negedge clk);
    chk("fp_second_vld", re_valid, 4'b1000);
    chk("fp_second_data", re_data, 256'h33);
    m_re_valid = 1'b0;
    @(negedge clk);

    // Concurrent read ch0 and write ch1.
    r_req[0] = 1'b1;
    r_addr[0*AW +: AW] = 32'h8000_2000;
    w_req[1] = 1'b1;
    w_addr[1*AW +: AW] = 32'h8000_1000;
    w_data[1*DW +: DW] = 256'hBEEF;
    w_type[1*TW +: TW] = 6'h05;
    w_strb[1*SW +: SW] = 16'h00FF;
    @(negedge clk);
    chk("cc_both_req", {m_r_req, m_w_req}, 2'b11);
    chk("cc_r_rdy", r_rdy, 4'b0001);
    chk("cc_w_addr", m_w_addr, 32'h8000_1000);
    chk("cc_w_strb", m_w_strb, 16'h00FF);
    r_req[0] = 1'b0;
    m_w_rdy = 1'b1;
    @(negedge clk);
    chk("cc_w_rdy", w_rdy, 4'b0010);
    chk("cc_r_still", m_r_req, 1'b1);
    m_w_rdy = 1'b0;
    m_r_rdy = 1'b1;
    @(negedge clk);
    chk("cc_no_regrant", {m_w_req, wr_busy}, 2'b00);
    chk("cc_r_wait", {m_r_req, rd_busy}, 2'b01);
    w_req[1] = 1'b0;
    m_r_rdy = 1'b0;
    m_re_valid = 1'b1;
    m_re_data = 256'h5A;
    @(negedge clk);
    chk("cc_r_vld", re_valid, 4'b0001);
    m_re_valid = 1'b0;
    @(negedge clk);

    // Grant lock and stray m_w_rdy in W_IDLE.
    r_req[2] = 1'b1;
    r_addr[2*AW +: AW] = 32'h1111_2220;
    r_type[2*TW +: TW] = 6'h07;
    @(negedge clk);
    r_req[2] = 1'b0;
    m_r_rdy = 1'b1;
    @(negedge clk);
    m_r_rdy = 1'b0;
    r_addr[2*AW +: AW] = 32'hBAD0_0000;
    r_type[2*TW +: TW] = 6'h38;
    m_w_rdy = 1'b1;
    @(negedge clk);
    chk("lk_addr", m_r_addr, 32'h1111_2220);
    chk("lk_type", m_r_type, 6'h07);
    chk("lk_w_rdy", w_rdy, 4'b0);
    m_w_rdy = 1'b0;
    @(negedge clk);
    chk("lk_stray_w_rdy", w_rdy, 4'b0);
    m_re_valid = 1'b1;
    m_re_data = 256'hC3;
    @(negedge clk);
    chk("lk_vld", re_valid, 4'b0100);
    m_re_valid = 1'b0;
    @(negedge clk);

    // Round-robin order on the second instance.
    rr_r_req = 4'hF;
    for (int c = 0; c < 60 && rr_got.size() < 5; c++) begin
      @(negedge clk);
      if (rr_r_rdy != '0) begin
        chk("rr_onehot", $countones(rr_r_rdy), 1);
        for (int k = 0; k < N; k++)
          if (rr_r_rdy[k]) rr_got.push_back(k);
      end
    end
    rr_r_req = '0;
    chk("rr_grants", rr_got.size(), 5);
    for (int i = 0; i < 5 && i < rr_got.size(); i++)
      chk($sformatf("rr_order%0d", i), rr_got[i], rr_exp[i]);
    repeat (6) @(negedge clk);

    // Reset in R_WAIT.
    r_req[1] = 1'b1;
    r_addr[1*AW +: AW] = 32'h4444_0000;
    r_type[1*TW +: TW] = 6'h09;
    @(negedge clk);
    r_req[1] = 1'b0;
    m_r_rdy = 1'b1;
    @(negedge clk);
    m_r_rdy = 1'b0;
    chk("rs_pre_busy", rd_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_busy", rd_busy, 1'b0);
    chk("rs_m_r_req", m_r_req, 1'b0);
    chk("rs_m_r_addr", m_r_addr, 32'h0);
    chk("rs_m_r_type", m_r_type, 6'h0);
    chk("rs_re_data", re_data, 256'h0);
    chk("rs_m_w_data", m_w_data, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_re_valid = 1'b1;
    m_re_data = 256'hEE;
    @(negedge clk);
    chk("rs_no_vld", re_valid, 4'b0);
    m_re_valid = 1'b0;
    @(negedge clk);
    chk("rs_no_vld2", re_valid, 4'b0);
    chk("rs_idle", rd_busy, 1'b0);

    chk("re_valid_count", n_rv, 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
